hazard_stall_ctrl: RTL and testbench

//   Parametrised load-use / memory-stall controller for the 5-stage pipeline, sitting beside
//   the ID stage. Detects load-use hazards with per-source "used" qualification and x0

---
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-stall controller beside the ID stage.
// Raises a configurable number of bubbles per load-use hazard, merges the
// data-cache busy stall into a pipeline-wide freeze, and counts stall cycles.
module hazard_stall_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LU_BUBBLES = 1,
  parameter bit X0_EXEMPT  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs_1_i,
  input  logic [REG_AW-1:0] rs_2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic              mem_stall_i,
  output logic              NoOp_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
  output logic              Freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Bubble counter has 4 bits, so 1..15 bubbles are representable.
  generate
    if (LU_BUBBLES < 1 || LU_BUBBLES > 15) begin : g_bad_lu_bubbles
      $error("hazard_stall_ctrl: LU_BUBBLES must be in 1..15");
    end
  endgenerate

  // First hazard cycle is the first bubble; the hold state counts the rest down to 0.
  localparam logic [3:0] LU_RELOAD = (LU_BUBBLES > 1) ? 4'(LU_BUBBLES - 2) : 4'd0;

  typedef enum logic {
    IDLE,
    LU_HOLD
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] bub_cnt;
  logic [3:0] bub_cnt_nxt;
  logic       rd_is_x0;
  logic       hazard;

  assign rd_is_x0 = X0_EXEMPT && (rd_i == '0);
  assign hazard   = MemRead_i && !rd_is_x0 &&
                    ((rs1_used_i && (rd_i == rs_1_i)) ||
                     (rs2_used_i && (rd_i == rs_2_i)));

  // State and bubble-count register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  // Next-state and prioritised outputs: reset, freeze, hold, hazard, run.
  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    NoOp_o      = 1'b0;
    Stall_o     = 1'b0;
    PCWrite_o   = 1'b1;
    Freeze_o    = 1'b0;
    if (!rst_i) begin
      // Outputs stay at run values while reset is asserted.
    end else if (mem_stall_i) begin
      // Freeze keeps state/bub_cnt, so bubble total is unaffected by cache stalls.
      Freeze_o  = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
    end else begin
      case (state)
        LU_HOLD: begin
          NoOp_o    = 1'b1;
          Stall_o   = 1'b1;
          PCWrite_o = 1'b0;
          if (bub_cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            bub_cnt_nxt = bub_cnt - 4'd1;
          end
        end
        default: begin
          if (hazard) begin
            NoOp_o    = 1'b1;
            Stall_o   = 1'b1;
            PCWrite_o = 1'b0;
            if (LU_BUBBLES > 1) begin
              state_nxt   = LU_HOLD;
              bub_cnt_nxt = LU_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // Saturating count of cycles with Stall_o asserted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (Stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: DUT A uses LU_BUBBLES=1, CNT_W=16; DUT B uses LU_BUBBLES=3, CNT_W=4.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A signals
  logic       rst_a = 1'b0, mr_a = 1'b0, u1_a = 1'b0, u2_a = 1'b0, ms_a = 1'b0;
  logic [4:0] rd_a = '0, r1_a = '0, r2_a = '0;
  logic       noop_a, stall_a, pcw_a, frz_a;
  logic [15:0] cnt_a;

  // DUT B signals
  logic       rst_b = 1'b0, mr_b = 1'b0, u1_b = 1'b0, u2_b = 1'b0, ms_b = 1'b0;
  logic [4:0] rd_b = '0, r1_b = '0, r2_b = '0;
  logic       noop_b, stall_b, pcw_b, frz_b;
  logic [3:0] cnt_b;

  hazard_stall_ctrl #(.REG_AW(5), .LU_BUBBLES(1), .X0_EXEMPT(1'b1), .CNT_W(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .MemRead_i(mr_a), .rd_i(rd_a), .rs_1_i(r1_a), .rs_2_i(r2_a),
    .rs1_used_i(u1_a), .rs2_used_i(u2_a), .mem_stall_i(ms_a),
    .NoOp_o(noop_a), .Stall_o(stall_a), .PCWrite_o(pcw_a), .Freeze_o(frz_a),
    .stall_cnt_o(cnt_a)
  );

  hazard_stall_ctrl #(.REG_AW(5), .LU_BUBBLES(3), .X0_EXEMPT(1'b1), .CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .MemRead_i(mr_b), .rd_i(rd_b), .rs_1_i(r1_b), .rs_2_i(r2_b),
    .rs1_used_i(u1_b), .rs2_used_i(u2_b), .mem_stall_i(ms_b),
    .NoOp_o(noop_b), .Stall_o(stall_b), .PCWrite_o(pcw_b), .Freeze_o(frz_b),
    .stall_cnt_o(cnt_b)
  );

  typedef struct packed {
    logic        dut;
    logic        noop;
    logic        stall;
    logic        pcw;
    logic        frz;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Drive one cycle of stimulus to the selected DUT (other DUT idles) and queue its expectation.
  task automatic step(input logic d, input logic rst, input logic mr,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic ms, input string nm,
                      input logic e_noop, input logic e_stall, input logic e_pcw,
                      input logic e_frz, input int e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 1'b0) begin
      rst_a = rst; mr_a = mr; rd_a = rd; r1_a = r1; r2_a = r2; u1_a = u1; u2_a = u2; ms_a = ms;
      rst_b = 1'b1; mr_b = 1'b0; rd_b = '0; r1_b = '0; r2_b = '0; u1_b = 1'b0; u2_b = 1'b0;
      ms_b = 1'b0;
    end else begin
      rst_b = rst; mr_b = mr; rd_b = rd; r1_b = r1; r2_b = r2; u1_b = u1; u2_b = u2; ms_b = ms;
      rst_a = 1'b1; mr_a = 1'b0; rd_a = '0; r1_a = '0; r2_a = '0; u1_a = 1'b0; u2_a = 1'b0;
      ms_a = 1'b0;
    end
    e.dut   = d;
    e.noop  = e_noop;
    e.stall = e_stall;
    e.pcw   = e_pcw;
    e.frz   = e_frz;
    e.cnt   = 16'(e_cnt);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Idle-input shorthand.
  task automatic idle(input logic d, input string nm, input logic e_noop, input logic e_stall,
                      input logic e_pcw, input logic e_frz, input int e_cnt);
    step(d, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, nm,
         e_noop, e_stall, e_pcw, e_frz, e_cnt);
  endtask

  // Monitor: outputs are valid every cycle, so compare on each falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [19:0] got;
      logic [19:0] want;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.dut == 1'b0) got = {noop_a, stall_a, pcw_a, frz_a, cnt_a};
      else               got = {noop_b, stall_b, pcw_b, frz_b, 12'd0, cnt_b};
      want = {e.noop, e.stall, e.pcw, e.frz, e.cnt};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got noop/stall/pcw/frz=%b%b%b%b cnt=%0d, expected %b%b%b%b cnt=%0d",
                 nm, got[19], got[18], got[17], got[16], got[15:0],
                 want[19], want[18], want[17], want[16], want[15:0]);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state: hazard inputs present but outputs forced to run values.
    step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, "a_reset_forced", 0,0,1,0, 0);
    idle(1'b0, "a_reset_release", 0,0,1,0, 0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "b_reset_forced", 0,0,1,0, 0);
    idle(1'b1, "b_reset_release", 0,0,1,0, 0);

    // Single bubble, LU_BUBBLES=1.
    step(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, "a_lu_rs1", 1,1,0,0, 0);
    idle(1'b0, "a_after_lu", 0,0,1,0, 1);
    idle(1'b0, "a_after_lu2", 0,0,1,0, 1);

    // x0 exemption and used qualification.
    step(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, "a_x0_exempt", 0,0,1,0, 1);
    step(1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, "a_rs2_unused", 0,0,1,0, 1);
    step(1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, "a_lu_rs2", 1,1,0,0, 1);
    step(1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, "a_no_memread", 0,0,1,0, 2);

    // Hazard and mem_stall together: freeze wins, hazard evaluated next cycle.
    step(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, "a_freeze_wins", 0,1,0,1, 2);
    step(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, "a_hazard_after", 1,1,0,0, 3);
    idle(1'b0, "a_idle_after", 0,0,1,0, 4);

    // LU_BUBBLES=3: exactly three bubbles, hazard ignored during hold.
    step(1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, "b_bub1", 1,1,0,0, 0);
    idle(1'b1, "b_bub2", 1,1,0,0, 1);
    step(1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, "b_bub3", 1,1,0,0, 2);
    idle(1'b1, "b_done", 0,0,1,0, 3);

    // Cache stall during second bubble: bubbles still total three.
    step(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, "b_ms_bub1", 1,1,0,0, 3);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "b_ms_frz1", 0,1,0,1, 4);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "b_ms_frz2", 0,1,0,1, 5);
    idle(1'b1, "b_ms_bub2", 1,1,0,0, 6);
    idle(1'b1, "b_ms_bub3", 1,1,0,0, 7);
    idle(1'b1, "b_ms_done", 0,0,1,0, 8);

    // Reset during hold aborts remaining bubbles.
    step(1'b1, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, "b_rst_bub1", 1,1,0,0, 8);
    idle(1'b1, "b_rst_bub2", 1,1,0,0, 9);
    step(1'b1, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, "b_rst_async", 0,0,1,0, 0);
    idle(1'b1, "b_rst_release", 0,0,1,0, 0);
    idle(1'b1, "b_rst_no_resid", 0,0,1,0, 0);

    // Saturating counter with CNT_W=4.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "b_sat_freeze",
           0,1,0,1, (i < 15) ? i : 15);
    end
    idle(1'b1, "b_sat_hold", 0,0,1,0, 15);
    idle(1'b1, "b_sat_hold2", 0,0,1,0, 15);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
